// File: rtl/ctrl_param_bank.sv
// Per-channel/per-slot control parameter store with a shadow bank that is
// committed atomically to the active bank at frame boundaries.
module ctrl_param_bank #(
    parameter int          N_CH       = 4,
    parameter int          N_SLOT     = 4,
    parameter logic [31:0] MAGIC      = 32'hF0AA550F,
    parameter logic [15:0] TS_DEFAULT = 16'd3600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_cmd_magic,
    input  logic [31:0]          i_cmd_command,
    input  logic                 i_cmd_vld,
    output logic                 o_cmd_rdy,
    input  logic                 i_frame_sync,
    input  logic [3:0]           i_slot,
    output logic [16*N_SLOT-1:0] o_ts_time,
    output logic [4*N_CH-1:0]    o_pulse_mask,
    output logic [8*N_CH-1:0]    o_pulse_hit,
    output logic [8*N_CH-1:0]    o_pulse_gnd,
    output logic [4*N_CH-1:0]    o_pulse_count,
    output logic [16*N_CH-1:0]   o_pulse_hush,
    output logic [2*N_CH-1:0]    o_adc_vchn,
    output logic [8*N_CH-1:0]    o_adc_tick,
    output logic [8*N_CH-1:0]    o_adc_ratio,
    output logic [8*N_CH-1:0]    o_dac_level,
    output logic [31:0]          o_rd_data,
    output logic                 o_rd_vld,
    input  logic                 i_rd_rdy,
    output logic                 o_pending,
    output logic                 o_err,
    output logic [15:0]          o_err_cnt
);

    localparam int         CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int         SW       = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
    localparam logic [4:0] N_CH_L   = 5'(N_CH);
    localparam logic [4:0] N_SLOT_L = 5'(N_SLOT);

    typedef struct packed {
        logic [3:0]  mask;
        logic [1:0]  vchn;
        logic [7:0]  hit;
        logic [7:0]  gnd;
        logic [3:0]  count;
        logic [15:0] hush;
        logic [7:0]  tick;
        logic [7:0]  ratio;
        logic [7:0]  dac;
    } param_t;

    function automatic param_t default_param(input int ch, input int slot);
        param_t p;
        logic   last;
        last    = (ch == N_CH - 1) && (slot == N_SLOT - 1);
        p.mask  = 4'(1 << (ch % 4));
        p.vchn  = 2'(ch % 4);
        p.hit   = last ? 8'd20 : 8'd40;
        p.gnd   = last ? 8'd60 : 8'd40;
        p.count = last ? 4'd1 : 4'd4;
        p.hush  = 16'd1000;
        p.tick  = 8'd64;
        p.ratio = 8'd12;
        p.dac   = 8'd120;
        return p;
    endfunction

    param_t      shadow [N_CH][N_SLOT];
    param_t      active [N_CH][N_SLOT];
    logic [15:0] ts_sh  [N_SLOT];
    logic [15:0] ts_act [N_SLOT];
    param_t      out_q  [N_CH];
    logic [15:0] ts_q   [N_SLOT];
    logic        pending;
    logic        rd_vld;

    // Command word fields; a readback names its target field code in data[3:0].
    logic        glb;
    logic [3:0]  ncmd, ch, slot, tgt;
    logic [15:0] data;
    logic [CW-1:0] ch_i;
    logic [SW-1:0] slot_i;
    logic        unused_bits;

    assign glb         = i_cmd_command[31];
    assign ncmd        = i_cmd_command[30:27];
    assign ch          = i_cmd_command[26:23];
    assign slot        = i_cmd_command[22:19];
    assign data        = i_cmd_command[15:0];
    assign tgt         = data[3:0];
    assign ch_i        = ch[CW-1:0];
    assign slot_i      = slot[SW-1:0];
    assign unused_bits = ^i_cmd_command[18:16];

    logic ch_ok, slot_ok, magic_ok, local_ok, rb_ok, cmd_ok;
    logic cmd_fire, frame_commit, commit, do_write, do_defaults, do_rb, err_now;

    assign ch_ok    = {1'b0, ch} < N_CH_L;
    assign slot_ok  = {1'b0, slot} < N_SLOT_L;
    assign magic_ok = (i_cmd_magic == MAGIC);
    // Slot-time writes/readbacks (code 10) are shared by all channels, so ch is not checked.
    assign local_ok = ~glb && (ncmd >= 4'd1) && (ncmd <= 4'd10) && slot_ok
                      && ((ncmd == 4'd10) || ch_ok);
    assign rb_ok    = glb && (ncmd == 4'd2) && (tgt >= 4'd1) && (tgt <= 4'd10) && slot_ok
                      && ((tgt == 4'd10) || ch_ok);
    assign cmd_ok   = magic_ok && (local_ok || (glb && (ncmd <= 4'd1)) || rb_ok);

    // Handshake: a command transfers on any cycle with i_cmd_vld && o_cmd_rdy.
    assign frame_commit = i_frame_sync && pending;
    assign o_cmd_rdy    = ~rd_vld && ~frame_commit;
    assign cmd_fire     = i_cmd_vld && o_cmd_rdy;
    assign do_write     = cmd_fire && magic_ok && local_ok;
    assign do_defaults  = cmd_fire && magic_ok && glb && (ncmd == 4'd1);
    assign do_rb        = cmd_fire && magic_ok && rb_ok;
    assign commit       = frame_commit || (cmd_fire && magic_ok && glb && (ncmd == 4'd0));
    assign err_now      = cmd_fire && ~cmd_ok;

    always_ff @(posedge clk) begin
        if (rst || do_defaults) begin
            for (int c = 0; c < N_CH; c++)
                for (int s = 0; s < N_SLOT; s++)
                    shadow[c][s] <= default_param(c, s);
            for (int s = 0; s < N_SLOT; s++)
                ts_sh[s] <= TS_DEFAULT;
        end else if (do_write) begin
            case (ncmd)
                4'd1:    shadow[ch_i][slot_i].mask  <= data[3:0];
                4'd2:    shadow[ch_i][slot_i].vchn  <= data[1:0];
                4'd3:    shadow[ch_i][slot_i].hit   <= data[7:0];
                4'd4:    shadow[ch_i][slot_i].gnd   <= data[7:0];
                4'd5:    shadow[ch_i][slot_i].hush  <= data;
                4'd6:    shadow[ch_i][slot_i].count <= data[3:0];
                4'd7:    shadow[ch_i][slot_i].dac   <= data[7:0];
                4'd8:    shadow[ch_i][slot_i].ratio <= data[7:0];
                4'd9:    shadow[ch_i][slot_i].tick  <= data[7:0];
                4'd10:   ts_sh[slot_i]              <= data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++)
                for (int s = 0; s < N_SLOT; s++)
                    active[c][s] <= default_param(c, s);
            for (int s = 0; s < N_SLOT; s++)
                ts_act[s] <= TS_DEFAULT;
        end else if (commit) begin
            active <= shadow;
            ts_act <= ts_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            pending <= 1'b0;
        else if (commit)
            pending <= 1'b0;
        else if (do_write || do_defaults)
            pending <= 1'b1;
    end

    // An out-of-range i_slot leaves the sequencer outputs at their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++)
                out_q[c] <= default_param(c, 0);
            for (int s = 0; s < N_SLOT; s++)
                ts_q[s] <= TS_DEFAULT;
        end else begin
            if ({1'b0, i_slot} < N_SLOT_L)
                for (int c = 0; c < N_CH; c++)
                    out_q[c] <= active[c][i_slot[SW-1:0]];
            ts_q <= ts_act;
        end
    end

    param_t      sel;
    logic [15:0] rb_val;

    assign sel = active[ch_i][slot_i];

    always_comb begin
        rb_val = '0;
        case (tgt)
            4'd1:    rb_val = {12'd0, sel.mask};
            4'd2:    rb_val = {14'd0, sel.vchn};
            4'd3:    rb_val = {8'd0, sel.hit};
            4'd4:    rb_val = {8'd0, sel.gnd};
            4'd5:    rb_val = sel.hush;
            4'd6:    rb_val = {12'd0, sel.count};
            4'd7:    rb_val = {8'd0, sel.dac};
            4'd8:    rb_val = {8'd0, sel.ratio};
            4'd9:    rb_val = {8'd0, sel.tick};
            4'd10:   rb_val = ts_act[slot_i];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld    <= 1'b0;
            o_rd_data <= '0;
        end else if (do_rb) begin
            rd_vld    <= 1'b1;
            o_rd_data <= {tgt, ch, slot, 4'd0, rb_val};
        end else if (rd_vld && i_rd_rdy) begin
            rd_vld    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_err <= err_now;
            if (err_now && (o_err_cnt != 16'hFFFF))
                o_err_cnt <= o_err_cnt + 16'd1;
        end
    end

    assign o_rd_vld  = rd_vld;
    assign o_pending = pending;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign o_pulse_mask [4*c +: 4]   = out_q[c].mask;
        assign o_pulse_hit  [8*c +: 8]   = out_q[c].hit;
        assign o_pulse_gnd  [8*c +: 8]   = out_q[c].gnd;
        assign o_pulse_count[4*c +: 4]   = out_q[c].count;
        assign o_pulse_hush [16*c +: 16] = out_q[c].hush;
        assign o_adc_vchn   [2*c +: 2]   = out_q[c].vchn;
        assign o_adc_tick   [8*c +: 8]   = out_q[c].tick;
        assign o_adc_ratio  [8*c +: 8]   = out_q[c].ratio;
        assign o_dac_level  [8*c +: 8]   = out_q[c].dac;
    end

    for (genvar s = 0; s < N_SLOT; s++) begin : g_ts
        assign o_ts_time[16*s +: 16] = ts_q[s];
    end

endmodule

// File: tb/tb_ctrl_param_bank.sv
// Bench for ctrl_param_bank: directed steps from the test plan followed by a
// randomized command mix, all checked against an array-based reference model.
module tb_ctrl_param_bank;

    localparam int          N_CH   = 4;
    localparam int          N_SLOT = 4;
    localparam logic [31:0] MAGIC  = 32'hF0AA550F;
    localparam int          MX     = (N_CH > N_SLOT) ? N_CH : N_SLOT;
    localparam int          VW     = (16 * MX < 32) ? 32 : 16 * MX;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          i_cmd_magic;
    logic [31:0]          i_cmd_command;
    logic                 i_cmd_vld;
    logic                 o_cmd_rdy;
    logic                 i_frame_sync;
    logic [3:0]           i_slot;
    logic [16*N_SLOT-1:0] o_ts_time;
    logic [4*N_CH-1:0]    o_pulse_mask;
    logic [8*N_CH-1:0]    o_pulse_hit;
    logic [8*N_CH-1:0]    o_pulse_gnd;
    logic [4*N_CH-1:0]    o_pulse_count;
    logic [16*N_CH-1:0]   o_pulse_hush;
    logic [2*N_CH-1:0]    o_adc_vchn;
    logic [8*N_CH-1:0]    o_adc_tick;
    logic [8*N_CH-1:0]    o_adc_ratio;
    logic [8*N_CH-1:0]    o_dac_level;
    logic [31:0]          o_rd_data;
    logic                 o_rd_vld;
    logic                 i_rd_rdy;
    logic                 o_pending;
    logic                 o_err;
    logic [15:0]          o_err_cnt;

    ctrl_param_bank #(.N_CH(N_CH), .N_SLOT(N_SLOT), .MAGIC(MAGIC)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_magic(i_cmd_magic), .i_cmd_command(i_cmd_command),
        .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy),
        .i_frame_sync(i_frame_sync), .i_slot(i_slot),
        .o_ts_time(o_ts_time),
        .o_pulse_mask(o_pulse_mask), .o_pulse_hit(o_pulse_hit),
        .o_pulse_gnd(o_pulse_gnd), .o_pulse_count(o_pulse_count),
        .o_pulse_hush(o_pulse_hush), .o_adc_vchn(o_adc_vchn),
        .o_adc_tick(o_adc_tick), .o_adc_ratio(o_adc_ratio),
        .o_dac_level(o_dac_level),
        .o_rd_data(o_rd_data), .o_rd_vld(o_rd_vld), .i_rd_rdy(i_rd_rdy),
        .o_pending(o_pending), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: field values indexed by their command code (1..9).
    int          sh [N_CH][N_SLOT][11];
    int          ac [N_CH][N_SLOT][11];
    int          ts_sh [N_SLOT];
    int          ts_ac [N_SLOT];
    bit          m_pend, m_err, m_rd;
    int          m_errcnt;
    logic [31:0] m_rd_data;

    function automatic int fw(input int n);
        case (n)
            1, 6:    return 4;
            2:       return 2;
            5, 10:   return 16;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] mk(input bit g, input int n, input int c, input int s, input int d);
        return {g, 4'(n), 4'(c), 4'(s), 3'b000, 16'(d)};
    endfunction

    task automatic model_defaults();
        bit last;
        for (int c = 0; c < N_CH; c++)
            for (int s = 0; s < N_SLOT; s++) begin
                last = (c == N_CH - 1) && (s == N_SLOT - 1);
                sh[c][s][1] = 1 << (c % 4);
                sh[c][s][2] = c % 4;
                sh[c][s][3] = last ? 20 : 40;
                sh[c][s][4] = last ? 60 : 40;
                sh[c][s][5] = 1000;
                sh[c][s][6] = last ? 1 : 4;
                sh[c][s][7] = 120;
                sh[c][s][8] = 12;
                sh[c][s][9] = 64;
            end
        for (int s = 0; s < N_SLOT; s++) ts_sh[s] = 3600;
    endtask

    task automatic model_commit();
        ac     = sh;
        ts_ac  = ts_sh;
        m_pend = 0;
    endtask

    task automatic model_apply(input logic [31:0] magic, input logic [31:0] cmd);
        int g, n, c, s, d, t, v;
        g = int'(cmd[31]);
        n = int'(cmd[30:27]);
        c = int'(cmd[26:23]);
        s = int'(cmd[22:19]);
        d = int'(cmd[15:0]);
        m_err = 0;
        m_rd  = 0;
        if (magic != MAGIC) m_err = 1;
        else if (g == 0) begin
            if (n < 1 || n > 10 || s >= N_SLOT || (n != 10 && c >= N_CH)) m_err = 1;
            else begin
                if (n == 10) ts_sh[s] = d;
                else sh[c][s][n] = d % (1 << fw(n));
                m_pend = 1;
            end
        end else if (n == 0) model_commit();
        else if (n == 1) begin
            model_defaults();
            m_pend = 1;
        end else if (n == 2) begin
            t = d % 16;
            if (t < 1 || t > 10 || s >= N_SLOT || (t != 10 && c >= N_CH)) m_err = 1;
            else begin
                v = (t == 10) ? ts_ac[s] : ac[c][s][t];
                m_rd = 1;
                m_rd_data = {4'(t), 4'(c), 4'(s), 4'd0, 16'(v)};
            end
        end else m_err = 1;
        if (m_err && m_errcnt < 65535) m_errcnt++;
    endtask

    function automatic logic [VW-1:0] vec(input int code, input int w, input int s);
        logic [VW-1:0] v = '0;
        for (int c = 0; c < N_CH; c++) v |= VW'(ac[c][s][code]) << (w * c);
        return v;
    endfunction

    function automatic logic [VW-1:0] ts_vec();
        logic [VW-1:0] v = '0;
        for (int s = 0; s < N_SLOT; s++) v |= VW'(ts_ac[s]) << (16 * s);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle lets the registered outputs follow i_slot/commit, then compare all.
    task automatic check_all(input int s);
        tick();
        chk("pulse_mask",  VW'(o_pulse_mask),  vec(1, 4, s));
        chk("adc_vchn",    VW'(o_adc_vchn),    vec(2, 2, s));
        chk("pulse_hit",   VW'(o_pulse_hit),   vec(3, 8, s));
        chk("pulse_gnd",   VW'(o_pulse_gnd),   vec(4, 8, s));
        chk("pulse_hush",  VW'(o_pulse_hush),  vec(5, 16, s));
        chk("pulse_count", VW'(o_pulse_count), vec(6, 4, s));
        chk("dac_level",   VW'(o_dac_level),   vec(7, 8, s));
        chk("adc_ratio",   VW'(o_adc_ratio),   vec(8, 8, s));
        chk("adc_tick",    VW'(o_adc_tick),    vec(9, 8, s));
        chk("ts_time",     VW'(o_ts_time),     ts_vec());
        chk("pending",     VW'(o_pending),     VW'(m_pend));
    endtask

    task automatic send(input logic [31:0] magic, input logic [31:0] cmd, input int hold);
        chk("cmd_rdy_idle", VW'(o_cmd_rdy), VW'(1'b1));
        i_cmd_magic   = magic;
        i_cmd_command = cmd;
        i_cmd_vld     = 1'b1;
        tick();
        i_cmd_vld     = 1'b0;
        model_apply(magic, cmd);
        chk("err_pulse", VW'(o_err),     VW'(m_err));
        chk("err_cnt",   VW'(o_err_cnt), VW'(m_errcnt));
        chk("pending",   VW'(o_pending), VW'(m_pend));
        chk("rd_vld",    VW'(o_rd_vld),  VW'(m_rd));
        if (m_rd) begin
            chk("rd_data", VW'(o_rd_data), VW'(m_rd_data));
            for (int k = 0; k < hold; k++) begin
                tick();
                chk("rd_vld_hold", VW'(o_rd_vld),  VW'(1'b1));
                chk("cmd_rdy_rd",  VW'(o_cmd_rdy), VW'(1'b0));
            end
            i_rd_rdy = 1'b1;
            tick();
            i_rd_rdy = 1'b0;
            chk("rd_vld_clr",  VW'(o_rd_vld),  VW'(1'b0));
            chk("cmd_rdy_ret", VW'(o_cmd_rdy), VW'(1'b1));
        end
    endtask

    task automatic frame();
        i_frame_sync = 1'b1;
        #1;
        chk("cmd_rdy_frame", VW'(o_cmd_rdy), VW'(!m_pend));
        tick();
        i_frame_sync = 1'b0;
        if (m_pend) model_commit();
        chk("pending_frame", VW'(o_pending), VW'(1'b0));
    endtask

    initial begin
        int r, n, c, s;
        logic [31:0] mg;

        rst = 1'b1;
        i_cmd_magic = MAGIC;
        i_cmd_command = '0;
        i_cmd_vld = 1'b0;
        i_frame_sync = 1'b0;
        i_slot = 4'd0;
        i_rd_rdy = 1'b0;
        m_errcnt = 0;
        model_defaults();
        model_commit();
        repeat (3) tick();
        chk("rst_cmd_rdy", VW'(o_cmd_rdy), VW'(1'b1));
        chk("rst_rd_vld",  VW'(o_rd_vld),  VW'(1'b0));
        chk("rst_err",     VW'(o_err),     VW'(1'b0));
        chk("rst_err_cnt", VW'(o_err_cnt), VW'(16'd0));
        chk("rst_pending", VW'(o_pending), VW'(1'b0));
        chk("rst_dac0",    VW'(o_dac_level[7:0]),    VW'(8'd120));
        chk("rst_ts3",     VW'(o_ts_time[63:48]),    VW'(16'd3600));
        chk("rst_mask2",   VW'(o_pulse_mask[11:8]),  VW'(4'b0100));
        rst = 1'b0;
        check_all(0);

        // Shadow write is invisible until the frame commit.
        send(MAGIC, mk(0, 7, 1, 2, 'h55), 0);
        i_slot = 4'd2;
        check_all(2);
        chk("dac1_pre",     VW'(o_dac_level[15:8]), VW'(8'd120));
        chk("pending_pre",  VW'(o_pending),         VW'(1'b1));
        frame();
        tick();
        chk("dac1_post",    VW'(o_dac_level[15:8]), VW'(8'h55));
        chk("pending_post", VW'(o_pending),         VW'(1'b0));
        check_all(2);

        send(MAGIC, mk(0, 3, 0, 0, 'hC8), 0);
        frame();
        i_slot = 4'd0;
        check_all(0);
        chk("hit0_full", VW'(o_pulse_hit[7:0]), VW'(8'hC8));

        send(MAGIC, mk(1, 2, 3, 1, 5), 5);
        chk("rb_hush", VW'(m_rd_data), VW'({4'd5, 4'd3, 4'd1, 4'd0, 16'd1000}));

        send(32'h0, mk(0, 7, 0, 0, 'h11), 0);
        send(MAGIC, mk(0, 7, N_CH, 0, 'h22), 0);
        chk("err_cnt_two", VW'(o_err_cnt), VW'(16'd2));
        check_all(0);

        send(MAGIC, mk(0, 10, 0, 0, 800), 0);
        send(MAGIC, mk(1, 1, 0, 0, 0), 0);
        send(MAGIC, mk(1, 0, 0, 0, 0), 0);
        check_all(0);
        chk("ts0_default", VW'(o_ts_time[15:0]), VW'(16'd3600));

        // Out-of-range slot holds the previous slot's outputs.
        i_slot = 4'd3;
        check_all(3);
        i_slot = 4'(N_SLOT);
        check_all(3);
        check_all(3);

        frame();
        for (int i = 0; i < 250; i++) begin
            r  = $urandom_range(0, 99);
            mg = ($urandom_range(0, 9) == 0) ? $urandom : MAGIC;
            if (r < 45) begin
                n = $urandom_range(0, 11);
                c = $urandom_range(0, N_CH);
                s = $urandom_range(0, N_SLOT);
                send(mg, mk(0, n, c, s, $urandom_range(0, 65535)), 0);
            end else if (r < 57) begin
                frame();
            end else if (r < 70) begin
                c = $urandom_range(0, N_CH);
                s = $urandom_range(0, N_SLOT);
                send(mg, mk(1, 2, c, s, $urandom_range(0, 11)), $urandom_range(0, 3));
            end else if (r < 76) begin
                send(mg, mk(1, $urandom_range(0, 1), 0, 0, 0), 0);
            end else if (r < 79) begin
                send(MAGIC, mk(1, $urandom_range(3, 15), 0, 0, 0), 0);
            end else begin
                s = $urandom_range(0, N_SLOT - 1);
                i_slot = 4'(s);
                check_all(s);
            end
        end

        frame();
        for (int k = 0; k < N_SLOT; k++) begin
            i_slot = 4'(k);
            check_all(k);
        end
        chk("final_err_cnt", VW'(o_err_cnt), VW'(m_errcnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
